// File: rtl/ram_stream_loader.sv
// rtl/ram_stream_loader.sv - packs a byte stream into RAM byte/halfword/word writes and holds the CPU until loaded
module ram_stream_loader #(
  parameter int ADDR_W     = 9,
  parameter int BYTE_W     = 8,
  parameter int LANES      = 4,
  parameter int BASE_ADDR  = 0,
  parameter int BIG_ENDIAN = 1,
  parameter int ACK_TMO    = 64
) (
  input  logic                    Clk,
  input  logic                    Clr,
  input  logic                    Start,
  input  logic [1:0]              Mode,
  input  logic [ADDR_W:0]         Len,
  input  logic                    InValid,
  input  logic [BYTE_W-1:0]       InByte,
  output logic                    InReady,
  output logic                    MemWrite,
  output logic [ADDR_W-1:0]       MemAddr,
  output logic [BYTE_W*LANES-1:0] MemData,
  output logic [LANES-1:0]        MemBE,
  input  logic                    MemAck,
  output logic                    Busy,
  output logic                    Done,
  output logic [1:0]              Err,
  output logic                    CpuHold
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int KW = LW + 1;
  localparam int RW = ADDR_W + 1;
  localparam int SW = ADDR_W + 2;
  localparam logic [SW-1:0] addr_limit = {2'b01, {ADDR_W{1'b0}}};
  localparam logic [LW-1:0] lane_max   = LW'(LANES - 1);

  typedef enum logic [2:0] {
    st_idle, st_collect, st_wait_ack, st_done, st_error
  } state_t;

  state_t                    state, state_nx;
  logic [RW-1:0]             addr;
  logic [RW-1:0]             remaining;
  logic [KW-1:0]             k;
  logic [BYTE_W*LANES-1:0]   pack;
  logic [LANES-1:0]          be;
  logic [1:0]                mode_r;
  logic [1:0]                err_r;
  logic [15:0]               tmo;

  logic [KW-1:0]             unit_size;
  logic [RW-1:0]             unit_bytes;
  logic [SW-1:0]             unit_end;
  logic                      ovf;
  logic                      accept;
  logic                      last_byte;
  logic                      ack_tmo_hit;
  logic [LW-1:0]             lane_lin;
  logic [LW-1:0]             lane;

  always_comb begin
    case (mode_r)
      2'b00:   unit_size = KW'(1);
      2'b01:   unit_size = KW'(2);
      default: unit_size = KW'(LANES);
    endcase
  end

  // Overflow is judged before the first byte of a unit, so an out-of-range unit never collects data.
  assign unit_bytes  = (remaining < RW'(unit_size)) ? remaining : RW'(unit_size);
  assign unit_end    = SW'(addr) + SW'(unit_bytes);
  assign ovf         = (state == st_collect) && (k == '0) && (unit_end > addr_limit);
  assign accept      = (state == st_collect) && !ovf && InValid;
  assign last_byte   = accept && ((k + KW'(1) == unit_size) || (remaining == RW'(1)));
  assign ack_tmo_hit = (tmo == 16'(ACK_TMO - 1)) && !MemAck;
  assign lane_lin    = addr[LW-1:0] + k[LW-1:0];
  assign lane        = (BIG_ENDIAN != 0) ? (lane_max - lane_lin) : lane_lin;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state <= st_idle;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      st_idle, st_done, st_error: begin
        if (Start) begin
          if (Mode == 2'b11)  state_nx = st_error;
          else if (Len == '0) state_nx = st_done;
          else                state_nx = st_collect;
        end
      end
      st_collect: begin
        if (ovf)            state_nx = st_error;
        else if (last_byte) state_nx = st_wait_ack;
      end
      st_wait_ack: begin
        if (MemAck)           state_nx = (remaining == '0) ? st_done : st_collect;
        else if (ack_tmo_hit) state_nx = st_error;
      end
      default: state_nx = st_idle;
    endcase
  end

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      addr      <= '0;
      remaining <= '0;
      k         <= '0;
      pack      <= '0;
      be        <= '0;
      mode_r    <= '0;
      err_r     <= '0;
      tmo       <= '0;
    end else begin
      tmo <= '0;
      case (state)
        st_idle, st_done, st_error: begin
          if (Start) begin
            mode_r    <= Mode;
            addr      <= RW'(BASE_ADDR);
            remaining <= Len;
            k         <= '0;
            pack      <= '0;
            be        <= '0;
            err_r     <= (Mode == 2'b11) ? 2'b11 : 2'b00;
          end
        end
        st_collect: begin
          if (ovf) begin
            err_r <= 2'b10;
          end else if (accept) begin
            pack[lane*BYTE_W +: BYTE_W] <= InByte;
            be[lane]                    <= 1'b1;
            k                           <= k + KW'(1);
            remaining                   <= remaining - RW'(1);
          end
        end
        st_wait_ack: begin
          if (MemAck) begin
            addr <= addr + RW'(unit_size);
            pack <= '0;
            be   <= '0;
            k    <= '0;
          end else if (ack_tmo_hit) begin
            err_r <= 2'b01;
            pack  <= '0;
            be    <= '0;
          end else begin
            tmo <= tmo + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    InReady  = (state == st_collect) && !ovf;
    MemWrite = (state == st_wait_ack);
    Busy     = (state == st_collect) || (state == st_wait_ack);
    Done     = (state == st_done);
    CpuHold  = (state != st_done);
    MemAddr  = addr[ADDR_W-1:0];
    MemData  = pack;
    MemBE    = be;
    Err      = err_r;
  end

endmodule
